// File: rtl/frame_swap_ctrl.sv
// frame_swap_ctrl: vblank-synchronised frame buffer swap controller.
// Starts the rasterizer (o_go), buffers its pixel writes and serves
// registered display reads from the front bank.
// Ports: i_clk, i_srst_n (sync, active-low), i_vblank, o_go, i_done,
//   i_write_en + write row/col/rgb, read row/col, o_red/o_green/o_blue,
//   o_front_sel, o_frame_count, o_overrun.
// Build option: FRAME_SWAP_DOUBLE_BUFFER_EN selects two banks;
//   undefined builds a single shared bank with o_front_sel held 0.
module frame_swap_ctrl #(
  parameter int VERT_RESOLUTION  = 60,
  parameter int HORIZ_RESOLUTION = 80
) (
  input  logic                                i_clk,
  input  logic                                i_srst_n,
  input  logic                                i_vblank,
  output logic                                o_go,
  input  logic                                i_done,
  input  logic                                i_write_en,
  input  logic [$clog2(VERT_RESOLUTION)-1:0]  i_vert_write_addr,
  input  logic [$clog2(HORIZ_RESOLUTION)-1:0] i_horiz_write_addr,
  input  logic [3:0]                          i_red,
  input  logic [3:0]                          i_green,
  input  logic [3:0]                          i_blue,
  input  logic [$clog2(VERT_RESOLUTION)-1:0]  i_vert_read_addr,
  input  logic [$clog2(HORIZ_RESOLUTION)-1:0] i_horiz_read_addr,
  output logic [3:0]                          o_red,
  output logic [3:0]                          o_green,
  output logic [3:0]                          o_blue,
  output logic                                o_front_sel,
  output logic [7:0]                          o_frame_count,
  output logic                                o_overrun
);

  localparam int VW    = $clog2(VERT_RESOLUTION);
  localparam int HW    = $clog2(HORIZ_RESOLUTION);
  localparam int DEPTH = VERT_RESOLUTION * HORIZ_RESOLUTION;
  localparam int LAW   = $clog2(DEPTH);
`ifdef FRAME_SWAP_DOUBLE_BUFFER_EN
  localparam int NB    = 2;
`else
  localparam int NB    = 1;
`endif
  localparam int MAW   = $clog2(NB * DEPTH);

  localparam logic [VW:0] VLIM = (VW + 1)'(VERT_RESOLUTION);
  localparam logic [HW:0] HLIM = (HW + 1)'(HORIZ_RESOLUTION);

  typedef enum logic [2:0] {
    IDLE      = 3'b001,
    RENDER    = 3'b010,
    WAIT_SWAP = 3'b100
  } state_t;

  state_t     state_q, state_d;
  logic       go_q, go_d;
  logic       ovr_q, ovr_d;
  logic       front_q, front_d;
  logic [7:0] cnt_q, cnt_d;
  logic       vb_q;
  logic       vb_edge;

  logic [11:0]    mem [NB * DEPTH];
  logic [11:0]    rgb_q;
  logic [LAW-1:0] wr_lin, rd_lin;
  logic [MAW-1:0] wr_idx, rd_idx;
  logic           wr_ok, rd_ok;

  assign vb_edge = i_vblank & ~vb_q;

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      ovr_q   <= 1'b0;
      front_q <= 1'b0;
      cnt_q   <= 8'd0;
      vb_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      ovr_q   <= ovr_d;
      front_q <= front_d;
      cnt_q   <= cnt_d;
      vb_q    <= i_vblank;
    end
  end

  always_comb begin
    state_d = state_q;
    go_d    = 1'b0;
    ovr_d   = 1'b0;
    front_d = front_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (vb_edge) begin
          go_d    = 1'b1;
          state_d = RENDER;
        end
      end
      RENDER: begin
        // A done pulse wins over a coincident edge; the swap waits.
        if (i_done) state_d = WAIT_SWAP;
        else if (vb_edge) ovr_d = 1'b1;
      end
      WAIT_SWAP: begin
        if (vb_edge) begin
`ifdef FRAME_SWAP_DOUBLE_BUFFER_EN
          front_d = ~front_q;
`else
          front_d = 1'b0;
`endif
          cnt_d   = cnt_q + 8'd1;
          go_d    = 1'b1;
          state_d = RENDER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_lin = LAW'(i_vert_write_addr) * LAW'(HORIZ_RESOLUTION)
                + LAW'(i_horiz_write_addr);
  assign rd_lin = LAW'(i_vert_read_addr) * LAW'(HORIZ_RESOLUTION)
                + LAW'(i_horiz_read_addr);

`ifdef FRAME_SWAP_DOUBLE_BUFFER_EN
  // Back bank is written, front bank is read.
  assign wr_idx = front_q ? MAW'(wr_lin)
                          : MAW'(DEPTH) + MAW'(wr_lin);
  assign rd_idx = front_q ? MAW'(DEPTH) + MAW'(rd_lin)
                          : MAW'(rd_lin);
`else
  assign wr_idx = MAW'(wr_lin);
  assign rd_idx = MAW'(rd_lin);
`endif

  assign wr_ok = i_srst_n && i_write_en && (state_q == RENDER)
              && ({1'b0, i_vert_write_addr} < VLIM)
              && ({1'b0, i_horiz_write_addr} < HLIM);
  assign rd_ok = ({1'b0, i_vert_read_addr} < VLIM)
              && ({1'b0, i_horiz_read_addr} < HLIM);

  // Frame memory is never reset; an abandoned frame keeps its pixels.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_idx] <= {i_red, i_green, i_blue};
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) rgb_q <= 12'd0;
    else if (rd_ok) rgb_q <= mem[rd_idx];
    else rgb_q <= 12'd0;
  end

  assign {o_red, o_green, o_blue} = rgb_q;
  assign o_go          = go_q;
  assign o_overrun     = ovr_q;
  assign o_front_sel   = front_q;
  assign o_frame_count = cnt_q;

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// tb_frame_swap_ctrl: directed bench for frame_swap_ctrl with a
// per-cycle reference model and hand-computed expectations.
module tb_frame_swap_ctrl;

  localparam int V = 60;
  localparam int H = 80;
`ifdef FRAME_SWAP_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_REND = 1;
  localparam int M_WAIT = 2;

  logic       i_clk = 1'b0;
  logic       srst_n, vblank, done, we;
  logic [5:0] wv, rv;
  logic [6:0] wh, rh;
  logic [3:0] r_in, g_in, b_in;
  logic       o_go, o_front_sel, o_overrun;
  logic [3:0] o_red, o_green, o_blue;
  logic [7:0] o_frame_count;

  always #5 i_clk = ~i_clk;

  frame_swap_ctrl #(.VERT_RESOLUTION(V), .HORIZ_RESOLUTION(H)) dut (
    .i_clk              (i_clk),
    .i_srst_n           (srst_n),
    .i_vblank           (vblank),
    .o_go               (o_go),
    .i_done             (done),
    .i_write_en         (we),
    .i_vert_write_addr  (wv),
    .i_horiz_write_addr (wh),
    .i_red              (r_in),
    .i_green            (g_in),
    .i_blue             (b_in),
    .i_vert_read_addr   (rv),
    .i_horiz_read_addr  (rh),
    .o_red              (o_red),
    .o_green            (o_green),
    .o_blue             (o_blue),
    .o_front_sel        (o_front_sel),
    .o_frame_count      (o_frame_count),
    .o_overrun          (o_overrun)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pixel memory kept as [bank][row][col].
  logic [11:0] mm [2][V][H];
  bit          mk [2][V][H];
  int          mode;
  bit          m_prev_vb, m_front, ev, rb, wbk, active = 1'b0;
  logic        m_go, m_ovr;
  logic [7:0]  m_cnt;
  logic [11:0] m_rgb;
  bit          m_rgb_known;

  always @(posedge i_clk) begin
    if (!srst_n) begin
      mode = M_IDLE; m_prev_vb = 1'b1; m_front = 1'b0;
      m_go = 1'b0; m_ovr = 1'b0; m_cnt = 8'd0;
      m_rgb = 12'd0; m_rgb_known = 1'b1; active = 1'b1;
    end else begin
      ev = vblank && !m_prev_vb;
      rb = DB ? m_front : 1'b0;
      wbk = DB ? !m_front : 1'b0;
      if (rv < V && rh < H) begin
        m_rgb = mm[rb][rv][rh];
        m_rgb_known = mk[rb][rv][rh];
      end else begin
        m_rgb = 12'd0;
        m_rgb_known = 1'b1;
      end
      if (mode == M_REND && we && wv < V && wh < H) begin
        mm[wbk][wv][wh] = {r_in, g_in, b_in};
        mk[wbk][wv][wh] = 1'b1;
      end
      m_go = 1'b0;
      m_ovr = 1'b0;
      if (mode == M_IDLE) begin
        if (ev) begin m_go = 1'b1; mode = M_REND; end
      end else if (mode == M_REND) begin
        if (done) mode = M_WAIT;
        else if (ev) m_ovr = 1'b1;
      end else if (ev) begin
        mode = M_REND; m_go = 1'b1; m_cnt = m_cnt + 8'd1;
        if (DB) m_front = !m_front;
      end
      m_prev_vb = vblank;
    end
  end

  always @(negedge i_clk) begin
    if (active) begin
      check("m_go", o_go, m_go);
      check("m_overrun", o_overrun, m_ovr);
      check("m_front", o_front_sel, m_front);
      check("m_count", o_frame_count, m_cnt);
      if (m_rgb_known)
        check("m_rgb", {o_red, o_green, o_blue}, m_rgb);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wr_px(input int row, input int col,
                       input logic [11:0] c);
    we = 1'b1;
    wv = 6'(row);
    wh = 7'(col);
    {r_in, g_in, b_in} = c;
    step(1);
    we = 1'b0;
  endtask

  task automatic rd_px(input int row, input int col,
                       input logic [11:0] exp, input string name);
    rv = 6'(row);
    rh = 7'(col);
    step(1);
    check(name, {o_red, o_green, o_blue}, exp);
  endtask

  task automatic vb_edge();
    vblank = 1'b0;
    step(1);
    vblank = 1'b1;
    step(1);
  endtask

  initial begin
    srst_n = 1'b0; vblank = 1'b1; done = 1'b0; we = 1'b0;
    wv = '0; wh = '0; r_in = '0; g_in = '0; b_in = '0;
    rv = 6'd0; rh = 7'd80;
    step(3);
    check("rst_go", o_go, 0);
    check("rst_front", o_front_sel, 0);
    check("rst_count", o_frame_count, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_rgb", {o_red, o_green, o_blue}, 0);

    srst_n = 1'b1;
    step(5);
    check("no_go_vblank_held", o_go, 0);
    vblank = 1'b0;
    step(2);
    vblank = 1'b1;
    step(1);
    check("go_first", o_go, 1);
    step(1);
    check("go_one_cycle", o_go, 0);

    wr_px(5, 10, 12'hF00);
    wr_px(0, 0, 12'h123);
    wr_px(1, 0, 12'h456);
    wr_px(60, 0, 12'hABC);
    wr_px(0, 80, 12'hFFF);
    done = 1'b1;
    step(1);
    done = 1'b0;
    step(2);
    vb_edge();
    check("swap_front", o_front_sel, DB);
    check("swap_count", o_frame_count, 1);
    check("swap_go", o_go, 1);
    rd_px(5, 10, 12'hF00, "rd_5_10");
    rd_px(0, 0, 12'h123, "rd_0_0");
    rd_px(1, 0, 12'h456, "rd_col80_dropped");
    rd_px(0, 80, 12'h000, "rd_col_oob");
    rd_px(60, 0, 12'h000, "rd_row_oob");
    rv = 6'd0; rh = 7'd80;

    repeat (2) begin
      vb_edge();
      check("overrun_pulse", o_overrun, 1);
      step(1);
      check("overrun_one_cycle", o_overrun, 0);
    end
    check("overrun_front", o_front_sel, DB);
    check("overrun_count", o_frame_count, 1);

    vblank = 1'b0;
    step(1);
    vblank = 1'b1;
    done = 1'b1;
    step(1);
    done = 1'b0;
    check("coinc_no_overrun", o_overrun, 0);
    check("coinc_no_go", o_go, 0);
    check("coinc_no_swap", o_frame_count, 1);
    vb_edge();
    check("coinc_next_go", o_go, 1);
    check("coinc_next_count", o_frame_count, 2);
    check("coinc_next_front", o_front_sel, 0);

    for (int i = 0; i < 100; i++)
      wr_px(10 + i / 80, i % 80, 12'(i * 37));
    rv = 6'd5; rh = 7'd10;
    srst_n = 1'b0;
    step(1);
    check("mid_rst_go", o_go, 0);
    check("mid_rst_front", o_front_sel, 0);
    check("mid_rst_count", o_frame_count, 0);
    check("mid_rst_overrun", o_overrun, 0);
    check("mid_rst_rgb", {o_red, o_green, o_blue}, 0);
    srst_n = 1'b1;
    wr_px(5, 10, 12'h0F0);
    step(3);
    check("no_go_after_rst", o_go, 0);
    vb_edge();
    check("go_after_rst", o_go, 1);
    done = 1'b1;
    step(1);
    done = 1'b0;
    vb_edge();
    check("rst_swap_count", o_frame_count, 1);
    check("rst_swap_front", o_front_sel, DB);
    rd_px(5, 10, 12'hF00, "idle_write_dropped");
    rd_px(10, 7, 12'h103, "mem_kept_10_7");
    rd_px(11, 19, 12'hE4F, "mem_kept_11_19");
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/frame_swap_ctrl.md
FRAME_SWAP_CTRL -- requirements
Module: frame_swap_ctrl

Interface
REQ-001 Parameter VERT_RESOLUTION, default 60, frame rows.
REQ-002 Parameter HORIZ_RESOLUTION, default 80, frame columns.
REQ-003 i_clk  input  1  sole clock, all logic on rising edge.
REQ-004 i_srst_n  input  1  reset, synchronous, active-low.
REQ-005 i_vblank  input  1  display vertical-blank level, synchronous to i_clk.
REQ-006 o_go  output  1  one-cycle start pulse to rasterizer.
REQ-007 i_done  input  1  rasterizer frame-complete pulse.
REQ-008 i_write_en  input  1  pixel write strobe from rasterizer.
REQ-009 i_vert_write_addr / i_horiz_write_addr  input  $clog2(VERT_RESOLUTION) / $clog2(HORIZ_RESOLUTION)  write row / column.
REQ-010 i_red, i_green, i_blue  input  4 each  write pixel colour.
REQ-011 i_vert_read_addr / i_horiz_read_addr  input  same widths as REQ-009  display read row / column.
REQ-012 o_red, o_green, o_blue  output  4 each  registered read pixel from front buffer.
REQ-013 o_front_sel  output  1  bank currently displayed.
REQ-014 o_frame_count  output  8  completed swaps, wraps 255->0.
REQ-015 o_overrun  output  1  one-cycle pulse: vblank edge arrived while still rendering.

Function
REQ-016 Storage SHALL be two banks of VERT_RESOLUTION*HORIZ_RESOLUTION x 12 bits; linear address = vert*HORIZ_RESOLUTION + horiz.
REQ-017 vblank edge SHALL be i_vblank=1 while previous-cycle sample=0; previous sample register resets to 1.
REQ-018 States SHALL be IDLE, RENDER, WAIT_SWAP, one-hot encoded; illegal encodings go to IDLE.
REQ-019 IDLE: on vblank edge, assert o_go next cycle, enter RENDER; otherwise remain.
REQ-020 RENDER: on i_done enter WAIT_SWAP; on vblank edge without i_done pulse o_overrun, stay RENDER.
REQ-021 i_done and vblank edge in the same RENDER cycle SHALL enter WAIT_SWAP with no swap, no o_overrun; swap occurs on the following edge.
REQ-022 WAIT_SWAP: on vblank edge toggle o_front_sel, increment o_frame_count, pulse o_go, enter RENDER, all in the same registered update.
REQ-023 Writes SHALL occur only when i_write_en=1 and state is RENDER, into bank ~o_front_sel.
REQ-024 Writes with row >= VERT_RESOLUTION or column >= HORIZ_RESOLUTION SHALL be dropped.
REQ-025 Reads SHALL come from bank o_front_sel with 1-cycle latency; out-of-range read address returns 0.
REQ-026 i_done outside RENDER SHALL be ignored; o_go SHALL never be high two consecutive cycles.

Reset
REQ-027 On i_srst_n=0 at a clock edge: state IDLE, o_go 0, o_front_sel 0, o_frame_count 0, o_overrun 0, o_red/o_green/o_blue 0.
REQ-028 Reset mid-RENDER SHALL abandon the frame; no swap occurs; memory contents are not cleared.

Configuration
REQ-029 Macro FRAME_SWAP_DOUBLE_BUFFER_EN defined: two banks, behaviour per REQ-016..025.
REQ-030 Macro undefined: single bank; writes and reads use it; o_front_sel held 0; WAIT_SWAP still waits for vblank edge and increments o_frame_count.

Verification
REQ-031 Reset release with i_vblank=1 held -> no o_go until vblank falls and rises again; then o_go high exactly one cycle.
REQ-032 Write (row 5, col 10, rgb F/0/0) in RENDER, i_done, vblank edge -> o_front_sel=1, o_frame_count=1; read (5,10) gives F/0/0 one cycle later.
REQ-033 Two vblank edges during RENDER without i_done -> two o_overrun pulses, o_front_sel unchanged, o_frame_count 0.
REQ-034 i_done coincident with vblank edge -> no swap that edge; swap and o_go at next edge.
REQ-035 Write to row 60 col 0 and read row 0 col 80 -> no memory change; read returns 0.
REQ-036 Assert i_srst_n=0 mid-RENDER after 100 writes -> all outputs 0, state IDLE, next o_go only after a fresh vblank edge.
